// File: rtl/reg_dump_reader.sv
// Walks a register-file read port over an inclusive address range and streams
// each (address, data) pair out through a valid/ready handshake.
module reg_dump_reader #(
   parameter int SKIP_X0 = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Start,
   input  logic        Abort,
   input  logic [4:0]  AddrStart,
   input  logic [4:0]  AddrEnd,
   output logic [4:0]  RegAddr,
   input  logic [31:0] RegData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [4:0]  OutAddr,
   output logic [31:0] OutData,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_end;
   logic [4:0]  r_reg_addr;
   logic [4:0]  r_out_addr;
   logic [31:0] r_out_data;
   logic        r_out_valid;
   logic [4:0]  w_start;
   logic        w_accept;
   logic        w_capture;
   logic        w_advance;
   logic        w_clr;
   logic        w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_start   = (SKIP_X0 != 0 && AddrStart == 5'd0) ? 5'd1 : AddrStart;
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_advance = 1'b0;
      w_clr     = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: if (!Abort && Start) begin
            w_accept = 1'b1;
            w_next   = (w_start > AddrEnd) ? S_DONE : S_READ;
         end
         S_READ: begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
         end
         S_HOLD: if (OutReady) begin
            w_clr = 1'b1;
            // Termination is on the end address, so the 5-bit increment never wraps.
            if (r_out_addr == r_end) begin
               w_next = S_DONE;
            end else begin
               w_advance = 1'b1;
               w_next    = S_READ;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Abort overrides everything, including a handshake in the same cycle.
      if (Abort && r_state != S_IDLE) begin
         w_next    = S_IDLE;
         w_capture = 1'b0;
         w_advance = 1'b0;
         w_clr     = 1'b1;
         w_done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_end       <= 5'd0;
         r_reg_addr  <= 5'd0;
         r_out_addr  <= 5'd0;
         r_out_data  <= 32'd0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_end      <= AddrEnd;
            r_reg_addr <= w_start;
         end
         if (w_capture) begin
            r_out_data  <= RegData;
            r_out_addr  <= r_reg_addr;
            r_out_valid <= 1'b1;
         end
         if (w_clr)     r_out_valid <= 1'b0;
         if (w_advance) r_reg_addr  <= r_reg_addr + 5'd1;
      end
   end

   assign RegAddr  = r_reg_addr;
   assign OutAddr  = r_out_addr;
   assign OutData  = r_out_data;
   assign OutValid = r_out_valid;
   assign Busy     = (r_state != S_IDLE);
   assign Done     = w_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected beats are queued at Start and
// popped by a negedge monitor as the sink accepts them.
module tb_reg_dump_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [4:0]  AddrStart = 5'd0;
   logic [4:0]  AddrEnd = 5'd0;
   logic [4:0]  RegAddr;
   logic [31:0] RegData;
   logic        OutValid;
   logic        OutReady;
   logic [4:0]  OutAddr;
   logic [31:0] OutData;
   logic        Busy;
   logic        Done;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] regs [32];
   int          errs = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          beat_cnt = 0;
   logic        rand_mode = 1'b0;
   logic        rnd_ready = 1'b0;
   logic        fix_ready = 1'b1;
   logic        hold_v = 1'b0;
   logic [4:0]  hold_a = 5'd0;
   logic [31:0] hold_d = 32'd0;

   reg_dump_reader #(.SKIP_X0(1)) dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
      .AddrStart(AddrStart), .AddrEnd(AddrEnd), .RegAddr(RegAddr),
      .RegData(RegData), .OutValid(OutValid), .OutReady(OutReady),
      .OutAddr(OutAddr), .OutData(OutData), .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   assign RegData  = regs[RegAddr];
   assign OutReady = rand_mode ? rnd_ready : fix_ready;

   always @(posedge clk) begin
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
   end

   // Inputs change at posedge+1, so negedge values are what the next posedge sees.
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (Done === 1'b1) done_cnt++;
         if (hold_v) begin
            checks++;
            if (OutValid !== 1'b1 || OutAddr !== hold_a || OutData !== hold_d) begin
               errs++;
               $display("FAIL stall_stable: got v=%0b a=%0d d=%h, held a=%0d d=%h",
                        OutValid, OutAddr, OutData, hold_a, hold_d);
            end
         end
         hold_v = 1'b0;
         if (OutValid === 1'b1 && Abort !== 1'b1) begin
            if (OutReady === 1'b1) begin
               checks++;
               beat_cnt++;
               if (exp_q.size() == 0) begin
                  errs++;
                  $display("FAIL unexpected_beat: got a=%0d d=%h, expected none", OutAddr, OutData);
               end else begin
                  e = exp_q.pop_front();
                  if (OutAddr !== e.a || OutData !== e.d) begin
                     errs++;
                     $display("FAIL beat: got a=%0d d=%h, expected a=%0d d=%h",
                              OutAddr, OutData, e.a, e.d);
                  end
               end
            end else begin
               hold_v = 1'b1;
               hold_a = OutAddr;
               hold_d = OutData;
            end
         end
      end
   end

   task automatic init_regs();
      for (int a = 0; a < 32; a++) regs[a] = 32'(a) * 32'h11111111;
   endtask

   task automatic push_range(input int s, input int e);
      int eff;
      eff = (s == 0) ? 1 : s;
      for (int a = eff; a <= e; a++) exp_q.push_back({5'(a), regs[a]});
   endtask

   task automatic start_dump(input logic [4:0] s, input logic [4:0] e);
      AddrStart = s;
      AddrEnd   = e;
      Start     = 1'b1;
      @(posedge clk); #1;
      Start     = 1'b0;
      AddrStart = 5'($urandom);
      AddrEnd   = 5'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (Done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({RegAddr, OutAddr, OutData, OutValid, Busy, Done} !== 44'd0) begin
         errs++;
         $display("FAIL reset_outputs: got ra=%0d oa=%0d od=%h v=%0b busy=%0b done=%0b, expected all 0",
                  RegAddr, OutAddr, OutData, OutValid, Busy, Done);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (Busy !== 1'b0) begin errs++; $display("FAIL reset_idle: busy=%0b expected 0", Busy); end
   endtask

   task automatic test_full_range();
      int d0, b0;
      bit ok;
      d0 = done_cnt; b0 = beat_cnt;
      fix_ready = 1'b1;
      push_range(0, 31);
      AddrStart = 5'd0; AddrEnd = 5'd31; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b1) begin
         errs++;
         $display("FAIL latency_first_edge: v=%0b busy=%0b, expected v=0 busy=1", OutValid, Busy);
      end
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || OutAddr !== 5'd1) begin
         errs++;
         $display("FAIL latency_second_edge: v=%0b a=%0d, expected v=1 a=1", OutValid, OutAddr);
      end
      wait_done(200, ok);
      checks++;
      if (!ok) begin errs++; $display("FAIL full_timeout: Done not seen, expected within 200 cycles"); end
      checks++;
      if (beat_cnt - b0 != 31 || exp_q.size() != 0) begin
         errs++;
         $display("FAIL full_count: beats=%0d left=%0d, expected 31 and 0", beat_cnt - b0, exp_q.size());
      end
      checks++;
      if (done_cnt - d0 != 1) begin errs++; $display("FAIL full_done: pulses=%0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_stall();
      int d0, b0;
      bit ok;
      d0 = done_cnt; b0 = beat_cnt;
      rand_mode = 1'b1;
      push_range(5, 7);
      start_dump(5'd5, 5'd7);
      wait_done(300, ok);
      rand_mode = 1'b0;
      checks++;
      if (!ok) begin errs++; $display("FAIL stall_timeout: Done not seen, expected within 300 cycles"); end
      checks++;
      if (beat_cnt - b0 != 3 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         errs++;
         $display("FAIL stall_count: beats=%0d left=%0d done=%0d, expected 3 0 1",
                  beat_cnt - b0, exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_empty(input logic [4:0] s, input logic [4:0] e);
      int d0, busy_n, v_n;
      d0 = done_cnt; busy_n = 0; v_n = 0;
      AddrStart = s; AddrEnd = e; Start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         Start = 1'b0;
         if (Busy === 1'b1) busy_n++;
         if (OutValid === 1'b1) v_n++;
      end
      checks++;
      if (busy_n != 1 || v_n != 0 || done_cnt - d0 != 1) begin
         errs++;
         $display("FAIL empty_%0d_%0d: busy=%0d valid=%0d done=%0d, expected 1 0 1",
                  s, e, busy_n, v_n, done_cnt - d0);
      end
   endtask

   task automatic test_abort();
      int d0, b0;
      bit found, ok;
      fix_ready = 1'b1;
      push_range(2, 10);
      start_dump(5'd2, 5'd10);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (OutValid === 1'b1 && OutAddr === 5'd4) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!found) begin errs++; $display("FAIL abort_find: beat 4 not seen, expected within 50 cycles"); end
      d0 = done_cnt;
      Abort = 1'b1;
      @(posedge clk); #1;
      Abort = 1'b0;
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b0) begin
         errs++;
         $display("FAIL abort_idle: v=%0b busy=%0b, expected 0 0", OutValid, Busy);
      end
      exp_q.delete();
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (done_cnt != d0) begin errs++; $display("FAIL abort_no_done: pulses=%0d expected 0", done_cnt - d0); end
      b0 = beat_cnt; d0 = done_cnt;
      push_range(2, 2);
      start_dump(5'd2, 5'd2);
      wait_done(50, ok);
      checks++;
      if (!ok || beat_cnt - b0 != 1 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         errs++;
         $display("FAIL abort_restart: ok=%0b beats=%0d left=%0d done=%0d, expected 1 1 0 1",
                  ok, beat_cnt - b0, exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_start_ignored();
      int d0, b0;
      bit ok;
      d0 = done_cnt; b0 = beat_cnt;
      push_range(1, 8);
      start_dump(5'd1, 5'd8);
      for (int i = 0; i < 6; i++) begin
         AddrStart = 5'd20; AddrEnd = 5'd25;
         Start = ~Start;
         @(posedge clk); #1;
      end
      Start = 1'b0;
      wait_done(100, ok);
      checks++;
      if (!ok || beat_cnt - b0 != 8 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         errs++;
         $display("FAIL start_ignored: ok=%0b beats=%0d left=%0d done=%0d, expected 1 8 0 1",
                  ok, beat_cnt - b0, exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_dump();
      int busy_n, v_n;
      push_range(1, 31);
      start_dump(5'd1, 5'd31);
      repeat (6) begin @(posedge clk); #1; end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({RegAddr, OutAddr, OutData, OutValid, Busy, Done} !== 44'd0) begin
         errs++;
         $display("FAIL reset_mid: got ra=%0d oa=%0d od=%h v=%0b busy=%0b done=%0b, expected all 0",
                  RegAddr, OutAddr, OutData, OutValid, Busy, Done);
      end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      busy_n = 0; v_n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (Busy === 1'b1) busy_n++;
         if (OutValid === 1'b1) v_n++;
      end
      checks++;
      if (busy_n != 0 || v_n != 0) begin
         errs++;
         $display("FAIL reset_no_restart: busy=%0d valid=%0d, expected 0 0", busy_n, v_n);
      end
   endtask

   task automatic test_negedge_write();
      int b0;
      bit found, ok;
      b0 = beat_cnt;
      for (int a = 10; a <= 14; a++)
         exp_q.push_back({5'(a), (a == 12) ? 32'hDEADBEEF : regs[a]});
      start_dump(5'd10, 5'd14);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (RegAddr === 5'd12) begin
            regs[12] = 32'hDEADBEEF;
            found = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      wait_done(50, ok);
      checks++;
      if (!found || !ok || beat_cnt - b0 != 5 || exp_q.size() != 0) begin
         errs++;
         $display("FAIL negedge_write: found=%0b ok=%0b beats=%0d left=%0d, expected 1 1 5 0",
                  found, ok, beat_cnt - b0, exp_q.size());
      end
      regs[12] = 32'hCCCCCCCC;
   endtask

   initial begin
      init_regs();
      test_reset();
      test_full_range();
      test_stall();
      test_empty(5'd9, 5'd3);
      test_empty(5'd0, 5'd0);
      test_abort();
      test_start_ignored();
      test_negedge_write();
      test_reset_mid_dump();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
